// File: rtl/pipedmem_resp.sv
// Data-memory responder for the MEM-stage load/store port: one word-addressed request at a time.
// Latency: request accepted in cycle k -> rsp_valid first high in cycle k+1+WAIT.
// Backpressure: req_ready low from acceptance until the response handshake; response held while rsp_ready=0.
//
// Ports:
//   clk, clr                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_we/addr/wdata/be          store flag, byte address, store data, store byte enables
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_err            load data (0 for stores/errors), misaligned/out-of-window flag
module pipedmem_resp #(
  parameter int          ADDR_W = 10,
  parameter int          WAIT   = 2,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          DEPTH     = 1 << ADDR_W;
  localparam int          HI        = ADDR_W + 2;
  localparam logic [3:0]  WAIT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;

  // Request latched at acceptance
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [3:0]  l_be;

  logic [31:0] mem [0:DEPTH-1];

  // Access operands: with WAIT=0 the access happens on the acceptance edge,
  // so the live request is used instead of the not-yet-latched copy.
  logic              a_we;
  logic [31:0]       a_addr;
  logic [31:0]       a_wdata;
  logic [3:0]        a_be;
  logic              a_err;
  logic [ADDR_W-1:0] a_idx;
  logic              go_resp;

  always_comb begin
    a_we    = l_we;
    a_addr  = l_addr;
    a_wdata = l_wdata;
    a_be    = l_be;
    if (state == ST_IDLE) begin
      a_we    = req_we;
      a_addr  = req_addr;
      a_wdata = req_wdata;
      a_be    = req_be;
    end
    a_err   = (a_addr[1:0] != 2'b00) | (a_addr[31:HI] != BASE[31:HI]);
    a_idx   = a_addr[HI-1:2];
    go_resp = ((state == ST_IDLE) && req_valid && (WAIT == 0)) ||
              ((state == ST_WAIT) && (cnt == 4'd0));
  end

  assign req_ready = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      l_we      <= 1'b0;
      l_addr    <= 32'd0;
      l_wdata   <= 32'd0;
      l_be      <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            l_we    <= req_we;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
            l_be    <= req_be;
            cnt     <= WAIT_INIT;
            state   <= (WAIT == 0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Entry into RESP: capture the response (only loads without error return data)
      if (go_resp) begin
        rsp_valid <= 1'b1;
        rsp_err   <= a_err;
        rsp_rdata <= (!a_we && !a_err) ? mem[a_idx] : 32'd0;
      end
    end
  end

  // Array is not reset; clr suppresses a write that would coincide with it.
  always_ff @(posedge clk) begin
    if (!clr && go_resp && a_we && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be[i]) mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_pipedmem_resp.sv
// Self-checking bench for pipedmem_resp: directed scenarios plus randomized traffic.
// Two instances: WAIT=2 (main) and WAIT=0 (back-to-back throughput).
// Expected results come from a word-array memory model in the bench.
module tb_pipedmem_resp;

  localparam int WAIT_MAIN = 2;
  localparam logic [31:0] WIN_BYTES = 32'd4096;   // 2^10 words * 4, window at base 0

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_we = 0, rsp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [3:0]  req_be = 0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid0 = 0, req_we0 = 0, rsp_ready0 = 0;
  logic [31:0] req_addr0 = 0, req_wdata0 = 0;
  logic [3:0]  req_be0 = 0;
  logic        req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0;

  pipedmem_resp #(.ADDR_W(10), .WAIT(WAIT_MAIN), .BASE(32'h0)) u_dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  pipedmem_resp #(.ADDR_W(10), .WAIT(0), .BASE(32'h0)) u_dut0 (
    .clk(clk), .clr(clr),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .req_be(req_be0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl  [0:1023];
  logic [31:0] mdl0 [0:1023];

  // Reference: a request errors if misaligned or outside the 4 KiB window;
  // stores merge enabled bytes, loads return the whole word.
  task automatic mdl_apply(input bit which, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be,
                           output logic [31:0] rd, output bit er);
    int w;
    logic [31:0] word;
    er = ((a % 4) != 0) || (a >= WIN_BYTES);
    rd = 32'd0;
    if (!er) begin
      w = int'(a / 4);
      word = which ? mdl0[w] : mdl[w];
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
        if (which) mdl0[w] = word; else mdl[w] = word;
      end else begin
        rd = word;
      end
    end
  endtask

  // Drives one request on the WAIT=2 instance and collects what it observed.
  task automatic run_txn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] be, input int hold,
                         output logic [31:0] rd, output logic er, output int lat,
                         output bit stable, output bit rdy_low, output bit rdy_back);
    @(posedge clk); #1;
    req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    rsp_ready = 0;
    @(posedge clk); #1;
    req_valid = 0;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata; er = rsp_err;
    stable = 1; rdy_low = (req_ready === 1'b0);
    req_valid = 1;   // must be ignored while busy
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== rd || rsp_err !== er) stable = 0;
      if (req_ready !== 1'b0) rdy_low = 0;
    end
    req_valid = 0;
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    rdy_back = (req_ready === 1'b1) && (rsp_valid === 1'b0);
  endtask

  task automatic test_reset();
    clr = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    clr = 0;
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat; bit st, rl, rb;
    run_txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, st, rl, rb);
    checks++; if (lat != WAIT_MAIN) begin errors++; $display("FAIL store_latency: got %0d want %0d", lat, WAIT_MAIN); end
    checks++; if (er !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL store_rsp: got err=%b rdata=%h want 0/0", er, rd); end
    checks++; if (!rb) begin errors++; $display("FAIL store_release: got req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid); end
    run_txn(0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st, rl, rb);
    checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin errors++; $display("FAIL load_after_store: got %h err=%b want deadbeef/0", rd, er); end
    checks++; if (lat != WAIT_MAIN) begin errors++; $display("FAIL load_latency: got %0d want %0d", lat, WAIT_MAIN); end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd; logic er; int lat; bit st, rl, rb;
    run_txn(1, 32'h20, 32'h11223344, 4'hF, 0, rd, er, lat, st, rl, rb);
    run_txn(1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat, st, rl, rb);
    run_txn(1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat, st, rl, rb);
    run_txn(0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, rl, rb);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL byte_enables: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; bit st, rl, rb;
    run_txn(1, 32'h0, 32'hCAFEF00D, 4'hF, 0, rd, er, lat, st, rl, rb);
    run_txn(0, 32'h22, 32'h0, 4'hF, 0, rd, er, lat, st, rl, rb);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_misaligned: got err=%b rdata=%h want 1/0", er, rd); end
    run_txn(1, 32'h1000, 32'h12345678, 4'hF, 0, rd, er, lat, st, rl, rb);
    checks++; if (er !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL err_range_store: got err=%b rdata=%h want 1/0", er, rd); end
    run_txn(1, 32'h2, 32'h87654321, 4'hF, 0, rd, er, lat, st, rl, rb);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_misaligned_store: got err=%b want 1", er); end
    run_txn(0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat, st, rl, rb);
    checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL err_no_write: got %h err=%b want cafef00d/0", rd, er); end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; bit st, rl, rb;
    run_txn(0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat, st, rl, rb);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_data: got %h want deadbeef", rd); end
    checks++; if (!st) begin errors++; $display("FAIL bp_stable: got stable=%b want 1", st); end
    checks++; if (!rl) begin errors++; $display("FAIL bp_req_ready_low: got low=%b want 1", rl); end
    checks++; if (!rb) begin errors++; $display("FAIL bp_release: got req_ready=%b rsp_valid=%b want 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int lat; bit st, rl, rb; bit quiet;
    run_txn(1, 32'h40, 32'h0BADC0DE, 4'hF, 0, rd, er, lat, st, rl, rb);
    @(posedge clk); #1;
    req_valid = 1; req_we = 1; req_addr = 32'h40; req_wdata = 32'h55; req_be = 4'hF;
    @(posedge clk); #1;            // accepted; now first WAIT cycle
    req_valid = 0;
    clr = 1;
    @(posedge clk); #1;
    clr = 0;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL midwait_outputs: got rdy=%b vld=%b rdata=%h err=%b want 1/0/0/0", req_ready, rsp_valid, rsp_rdata, rsp_err);
    end
    quiet = 1;
    repeat (6) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) quiet = 0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL midwait_discard: got a response want none"); end
    run_txn(0, 32'h40, 32'h0, 4'h0, 0, rd, er, lat, st, rl, rb);
    checks++; if (rd !== 32'h0BADC0DE) begin errors++; $display("FAIL midwait_no_write: got %h want 0badc0de", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, exp_rd, a, wd; logic er; bit exp_er, we; logic [3:0] be;
    int lat, hold, bad_d, bad_l; bit st, rl, rb;
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      mdl_apply(0, 1, 32'h300 + 32'(i * 4), wd, 4'hF, exp_rd, exp_er);
      run_txn(1, 32'h300 + 32'(i * 4), wd, 4'hF, 0, rd, er, lat, st, rl, rb);
    end
    bad_d = 0; bad_l = 0;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = 32'h300 + 32'($urandom_range(0, 15) * 4);
      case ($urandom_range(0, 7))
        0: a = a + 32'($urandom_range(1, 3));
        1: a = a + 32'h1000;
        2: a = a | 32'h8000_0000;
        default: ;
      endcase
      wd = $urandom; be = 4'($urandom); hold = $urandom_range(0, 3);
      mdl_apply(0, we, a, wd, be, exp_rd, exp_er);
      run_txn(we, a, wd, be, hold, rd, er, lat, st, rl, rb);
      if (rd !== exp_rd || er !== exp_er || !st || !rb) begin
        bad_d++;
        $display("FAIL rand_txn%0d: addr=%h we=%b got %h err=%b want %h err=%b", n, a, we, rd, er, exp_rd, exp_er);
      end
      if (lat != WAIT_MAIN) bad_l++;
    end
    checks++; if (bad_d != 0) begin errors++; $display("FAIL rand_data: got %0d bad txns want 0", bad_d); end
    checks++; if (bad_l != 0) begin errors++; $display("FAIL rand_latency: got %0d bad txns want 0", bad_l); end
  endtask

  task automatic test_back_to_back();
    localparam int N = 24;
    bit          t_we [N];
    logic [31:0] t_a [N], t_wd [N], t_rd [N];
    logic [3:0]  t_be [N];
    bit          t_er [N];
    int nxt, cur, nacc, bad_acc, bad_rsp;
    bit acc, prev_acc;
    for (int j = 0; j < N; j++) begin
      if (j < 8) begin
        t_we[j] = 1; t_a[j] = 32'h100 + 32'(j * 4); t_be[j] = 4'hF;
      end else begin
        t_we[j] = (j % 2 == 0);
        t_a[j]  = 32'h100 + 32'(((j - 8) / 2 % 8) * 4);
        t_be[j] = 4'($urandom);
      end
      if (j == 20) t_a[j] = 32'h1234_5670;   // one out-of-window request
      t_wd[j] = $urandom;
      mdl_apply(1, t_we[j], t_a[j], t_wd[j], t_be[j], t_rd[j], t_er[j]);
    end
    @(posedge clk); #1;
    rsp_ready0 = 1; req_valid0 = 1;
    req_we0 = t_we[0]; req_addr0 = t_a[0]; req_wdata0 = t_wd[0]; req_be0 = t_be[0];
    nxt = 0; cur = 0; nacc = 0; bad_acc = 0; bad_rsp = 0; prev_acc = 0;
    for (int cyc = 0; cyc < 2 * N + 2; cyc++) begin
      acc = req_valid0 && req_ready0;
      if (req_valid0 && (acc != (cyc % 2 == 0))) bad_acc++;
      if (acc) begin cur = nxt; nxt++; nacc++; end
      prev_acc = acc;
      @(posedge clk); #1;
      if (prev_acc) begin
        if (rsp_valid0 !== 1'b1 || rsp_rdata0 !== t_rd[cur] || rsp_err0 !== t_er[cur]) begin
          bad_rsp++;
          $display("FAIL b2b_rsp%0d: got vld=%b %h err=%b want 1 %h err=%b", cur, rsp_valid0, rsp_rdata0, rsp_err0, t_rd[cur], t_er[cur]);
        end
        if (nxt < N) begin
          req_we0 = t_we[nxt]; req_addr0 = t_a[nxt]; req_wdata0 = t_wd[nxt]; req_be0 = t_be[nxt];
        end else begin
          req_valid0 = 0;
        end
      end else if (rsp_valid0 !== 1'b0) begin
        bad_rsp++;
        $display("FAIL b2b_spurious: got rsp_valid=1 at cycle %0d want 0", cyc);
      end
    end
    req_valid0 = 0; rsp_ready0 = 0;
    checks++; if (nacc != N) begin errors++; $display("FAIL b2b_count: got %0d acceptances want %0d", nacc, N); end
    checks++; if (bad_acc != 0) begin errors++; $display("FAIL b2b_period: got %0d off-cadence cycles want 0", bad_acc); end
    checks++; if (bad_rsp != 0) begin errors++; $display("FAIL b2b_responses: got %0d bad cycles want 0", bad_rsp); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enables();
    test_errors();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
